regbus_master: RTL
==================

Name: regbus_master

Overview:
- Initiator for the byte-serial register bus served by the 4-register slave (addr/valid/ready/wr_n handshake, 4-beat LSB-first byte bursts).
- Accepts 32-bit read/write commands on a simple valid/ready command port and sequences the request, handshake and burst on the bus.
- Returns one response per command: read data or write completion, with an error flag on handshake timeout.
- Sits between test/system logic and the slave; the bench uses it as the reference driver.

Parameters:
TIMEOUT, 16, max cycles valid_o waits for ready_i before abort; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_wr  input  1  1 = write, 0 = read
cmd_addr  input  2  register index 0..3
cmd_wdata  input  32  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  32  read data; 0 for writes and errors
rsp_err  output  1  1 = handshake timeout
valid_o  output  1  bus request valid
addr_o  output  2  bus address
wr_n_o  output  1  bus direction, 0 = write
data_o  output  8  bus write byte
ready_i  input  1  bus ready from slave
data_i  input  8  bus read byte from slave

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, valid_o=0, addr_o=0, wr_n_o=1, data_o=0. State is IDLE.
- A reset mid-transaction aborts immediately with the reset values and drops any pending response. The slave is reset alongside.
- FSM states: IDLE, REQ, BURST, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd accept, latch cmd_wr/addr/wdata and go to REQ next cycle.
  - In REQ: valid_o=1, addr_o=addr, wr_n_o=!cmd_wr, data_o=wdata[7:0] for writes.
- REQ:
  - Hold valid_o/addr_o/wr_n_o/data_o stable.
  - Handshake cycle T is the cycle where valid_o && ready_i.
  - At the edge ending T: valid_o=0, go to BURST, beat counter=0.
  - Timeout counter counts REQ cycles. If it reaches TIMEOUT without a handshake: valid_o=0, go to RESP with rsp_err=1, rsp_rdata=0.
  - If ready_i arrives in the same cycle the timeout expires, the handshake wins.
- BURST: exactly 4 cycles, T+1..T+4, beat k = 0..3.
  - Write: data_o = wdata[15:8] in T+1, wdata[23:16] in T+2, wdata[31:24] in T+3, 0 in T+4. Byte k appears on data_o in cycle T+k, byte 0 in T itself.
  - Read: capture data_i into rdata[8k +: 8] in cycle T+1+k.
  - After T+4, go to RESP.
- RESP:
  - rsp_valid=1 from T+5; rsp_rdata = rdata for reads, 0 for writes; rsp_err=0.
  - Hold until rsp_ready, then go to IDLE with rsp_valid=0.
  - Earliest next valid_o is T+7 (RESP→IDLE→REQ). This satisfies the slave rule that no request is raised before its burst ends at T+4.
- ready_i outside REQ is ignored. data_i outside BURST is ignored.
- cmd_ready is 0 in every state except IDLE. One outstanding command only.

Test Plan:
- Write addr 1, wdata 0xDEADBEEF; slave ready 1 cycle after valid -> data_o = EF, BE, AD, DE in T..T+3; rsp_valid at T+5, rsp_err=0, rsp_rdata=0.
- Read addr 1 after the above -> data_i captured T+1..T+4; rsp_rdata=0xDEADBEEF.
- Write all 4 addresses with 0x11111111·(i+1), then read all back -> each read matches; no valid_o within 5 cycles of the prior handshake.
- Slave ready held low, TIMEOUT=16 -> valid_o drops after 16 cycles; rsp_err=1, rsp_rdata=0; bus idle afterwards.
- rsp_ready held low for 10 cycles -> rsp_valid/rsp_rdata stable; cmd_ready=0; no bus activity until accepted.
- rst asserted in BURST cycle T+2 of a write -> next cycle all outputs at reset values; a subsequent read of that address after slave reset returns 0.

Source files
------------

// File: rtl/regbus_master.sv
// Initiator for the byte-serial 4-register bus. It takes one 32-bit read or write command at a time,
// performs the request handshake and the 4-beat LSB-first burst, and returns a single response.
module regbus_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [1:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        valid_o,
   output logic [1:0]  addr_o,
   output logic        wr_n_o,
   output logic [7:0]  data_o,
   input  logic        ready_i,
   input  logic [7:0]  data_i
);

   typedef enum logic [1:0] {IDLE, REQ, BURST, RESP} state_t;

   state_t      state;
   logic        is_wr;
   logic [1:0]  beat;
   logic [31:0] tcnt;
   logic [31:0] wshift;   // write bytes still to send; the next one sits in [15:8]
   logic [23:0] rdata;    // read bytes enter at the top and shift down

   function automatic logic timed_out(input logic [31:0] cnt);
      return (TIMEOUT != 0) && (cnt == TIMEOUT - 1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         valid_o   <= 1'b0;
         addr_o    <= '0;
         wr_n_o    <= 1'b1;
         data_o    <= '0;
         is_wr     <= 1'b0;
         beat      <= '0;
         tcnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  is_wr     <= cmd_wr;
                  valid_o   <= 1'b1;
                  addr_o    <= cmd_addr;
                  wr_n_o    <= !cmd_wr;
                  wshift    <= cmd_wr ? cmd_wdata : '0;
                  data_o    <= cmd_wr ? cmd_wdata[7:0] : '0;
                  tcnt      <= '0;
                  state     <= REQ;
               end
            end

            REQ: begin
               // A handshake in the cycle the timeout expires still counts as a handshake.
               if (ready_i) begin
                  valid_o <= 1'b0;
                  data_o  <= wshift[15:8];
                  wshift  <= wshift >> 8;
                  beat    <= '0;
                  state   <= BURST;
               end else if (timed_out(tcnt)) begin
                  valid_o   <= 1'b0;
                  data_o    <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else begin
                  tcnt <= tcnt + 32'd1;
               end
            end

            BURST: begin
               data_o <= wshift[15:8];
               wshift <= wshift >> 8;
               rdata  <= {data_i, rdata[23:8]};
               beat   <= beat + 2'd1;
               if (beat == 2'd3) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= is_wr ? 32'd0 : {data_i, rdata};
                  state     <= RESP;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
